// File: rtl/model_loader.sv
// Decodes a host word stream into CSRAM / token-controller writes broadcast to every core, and sequences rst_model.
// Optional END-word checksum check is built in when MODEL_LOADER_CHECKSUM_EN is defined.
module model_loader #(
    parameter int WORD_WIDTH       = 32,
    parameter int NUM_CORES        = 999,
    parameter int NUM_NEURONS      = 256,
    parameter int NUM_AXONS        = 256,
    parameter int NUM_WEIGHTS      = 4,
    parameter int CSRAM_READ_WIDTH = 367,
    parameter int CLEAR_CYCLES     = 2,
    localparam int CW  = $clog2(NUM_CORES),
    localparam int AWN = $clog2(NUM_NEURONS),
    localparam int AWA = $clog2(NUM_AXONS),
    localparam int WW  = $clog2(NUM_WEIGHTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [WORD_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        rst_model,
    output logic [CSRAM_READ_WIDTH-1:0] csram_data,
    output logic [AWN-1:0]              csram_addr,
    output logic [CW-1:0]               csram_core_idx,
    output logic                        csram_valid,
    output logic [WW-1:0]               tc_data,
    output logic [AWA-1:0]              tc_addr,
    output logic [CW-1:0]               tc_core_idx,
    output logic                        tc_valid,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);

    localparam int AW        = (AWN > AWA) ? AWN : AWA;
    localparam int NUM_BEATS = (CSRAM_READ_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int ASM_W     = NUM_BEATS * WORD_WIDTH;
    localparam int BW        = $clog2(NUM_BEATS + 1);
    localparam int CCW       = $clog2(CLEAR_CYCLES + 1);
    localparam logic [CW:0] CORE_LIMIT = (CW + 1)'(NUM_CORES);
    localparam logic [1:0] T_CSRAM = 2'b00;
    localparam logic [1:0] T_TC    = 2'b01;
    localparam logic [1:0] T_END   = 2'b11;

    if (2 + CW + AW + WW > WORD_WIDTH) begin : g_bad_fields
        $error("model_loader: header fields do not fit in WORD_WIDTH");
    end
    if (CLEAR_CYCLES < 1) begin : g_bad_clear
        $error("model_loader: CLEAR_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_HEADER,
        S_DATA,
        S_ISSUE
    } state_t;

    state_t state, state_nxt;

    logic [CCW-1:0]   clr_cnt;
    logic [BW-1:0]    beat_cnt;
    logic [ASM_W-1:0] asm_q, asm_nxt;
    logic             rec_tc, rec_bad;
    logic [CW-1:0]    rec_core;
    logic [AWN-1:0]   rec_addr;
`ifdef MODEL_LOADER_CHECKSUM_EN
    logic [15:0]      sum_q;
`endif

    logic [1:0]    hdr_type;
    logic [CW-1:0] hdr_core;
    logic [AW-1:0] hdr_addr;
    logic          hdr_bad_core, hs, last_beat, clear_last;

    assign hdr_type     = in_data[WORD_WIDTH-1 -: 2];
    assign hdr_core     = in_data[WORD_WIDTH-3 -: CW];
    assign hdr_addr     = in_data[WORD_WIDTH-3-CW -: AW];
    assign hdr_bad_core = {1'b0, hdr_core} >= CORE_LIMIT;
    assign hs           = in_valid && in_ready;
    assign last_beat    = beat_cnt == BW'(NUM_BEATS - 1);
    assign clear_last   = clr_cnt == CCW'(CLEAR_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        busy        = 1'b1;
        csram_valid = 1'b0;
        tc_valid    = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_CLEAR;
            end
            S_CLEAR: if (clear_last) state_nxt = S_HEADER;
            S_HEADER: begin
                in_ready = 1'b1;
                if (hs) begin
                    case (hdr_type)
                        T_CSRAM: state_nxt = S_DATA;
                        T_TC:    state_nxt = S_ISSUE;
                        default: state_nxt = S_IDLE;
                    endcase
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (hs && last_beat) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                // Out-of-range records still pass through ISSUE but stay silent.
                csram_valid = !rec_tc && !rec_bad;
                tc_valid    = rec_tc && !rec_bad;
                state_nxt   = S_HEADER;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        asm_nxt = asm_q;
        asm_nxt[int'(beat_cnt) * WORD_WIDTH +: WORD_WIDTH] = in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rst_model      <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            clr_cnt        <= '0;
            beat_cnt       <= '0;
            asm_q          <= '0;
            rec_tc         <= 1'b0;
            rec_bad        <= 1'b0;
            rec_core       <= '0;
            rec_addr       <= '0;
            csram_data     <= '0;
            csram_addr     <= '0;
            csram_core_idx <= '0;
            tc_data        <= '0;
            tc_addr        <= '0;
            tc_core_idx    <= '0;
`ifdef MODEL_LOADER_CHECKSUM_EN
            sum_q          <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        error     <= 1'b0;
                        rst_model <= 1'b0;
                        clr_cnt   <= '0;
`ifdef MODEL_LOADER_CHECKSUM_EN
                        sum_q     <= '0;
`endif
                    end
                end
                S_CLEAR: begin
                    if (clear_last) rst_model <= 1'b1;
                    else            clr_cnt   <= clr_cnt + 1'b1;
                end
                S_HEADER: begin
                    if (hs) begin
`ifdef MODEL_LOADER_CHECKSUM_EN
                        if (hdr_type != T_END) sum_q <= sum_q + in_data[15:0];
`endif
                        case (hdr_type)
                            T_CSRAM: begin
                                rec_tc   <= 1'b0;
                                rec_bad  <= hdr_bad_core;
                                rec_core <= hdr_core;
                                rec_addr <= hdr_addr[AWN-1:0];
                                asm_q    <= '0;
                                beat_cnt <= '0;
                                if (hdr_bad_core) error <= 1'b1;
                            end
                            T_TC: begin
                                rec_tc  <= 1'b1;
                                rec_bad <= hdr_bad_core;
                                if (hdr_bad_core) begin
                                    error <= 1'b1;
                                end else begin
                                    tc_core_idx <= hdr_core;
                                    tc_addr     <= hdr_addr[AWA-1:0];
                                    tc_data     <= in_data[WW-1:0];
                                end
                            end
                            T_END: begin
                                done <= 1'b1;
`ifdef MODEL_LOADER_CHECKSUM_EN
                                if (sum_q != in_data[15:0]) error <= 1'b1;
`endif
                            end
                            default: error <= 1'b1;
                        endcase
                    end
                end
                S_DATA: begin
                    if (hs) begin
`ifdef MODEL_LOADER_CHECKSUM_EN
                        sum_q <= sum_q + in_data[15:0];
`endif
                        asm_q    <= asm_nxt;
                        beat_cnt <= beat_cnt + 1'b1;
                        // Output registers load on the last beat so they are stable during ISSUE.
                        if (last_beat && !rec_bad) begin
                            csram_data     <= asm_nxt[CSRAM_READ_WIDTH-1:0];
                            csram_addr     <= rec_addr;
                            csram_core_idx <= rec_core;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_model_loader.sv
// Directed bench for model_loader: TC/CSRAM records, range error, illegal type, mid-record reset, optional checksum.
module tb_model_loader;

    logic         clk = 1'b0;
    logic         rst, start, in_valid, in_ready, rst_model;
    logic [31:0]  in_data;
    logic [366:0] csram_data;
    logic [7:0]   csram_addr, tc_addr;
    logic [9:0]   csram_core_idx, tc_core_idx;
    logic [1:0]   tc_data;
    logic         csram_valid, tc_valid, busy, done, error;

    model_loader dut (
        .clk(clk), .rst(rst), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .rst_model(rst_model),
        .csram_data(csram_data), .csram_addr(csram_addr),
        .csram_core_idx(csram_core_idx), .csram_valid(csram_valid),
        .tc_data(tc_data), .tc_addr(tc_addr), .tc_core_idx(tc_core_idx),
        .tc_valid(tc_valid), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_bad = 0;
    int n_csram = 0, n_tc = 0, n_done = 0, n_rst_low = 0, n_bad_strobe = 0;
    logic [15:0]  tb_sum;
    logic [383:0] exp_csram;

    always @(negedge clk) begin
        if (csram_valid) n_csram++;
        if (tc_valid) n_tc++;
        if (done) n_done++;
        if (busy && !rst_model) n_rst_low++;
        if ((csram_valid || tc_valid) && !rst_model) n_bad_strobe++;
    end

    task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_hdr(input logic [1:0] t, input int core, input int addr, input int td);
        logic [31:0] w;
        w        = '0;
        w[31:30] = t;
        w[29:20] = core[9:0];
        w[19:12] = addr[7:0];
        w[1:0]   = td[1:0];
        return w;
    endfunction

    task automatic do_start();
        @(posedge clk); #1;
        start  = 1'b1;
        tb_sum = '0;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        int t;
        t        = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) chk("handshake_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        tb_sum   = tb_sum + w[15:0];
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_end(input logic [15:0] payload);
        logic [31:0] w;
        w        = '0;
        w[31:30] = 2'b11;
        w[15:0]  = payload;
        send_word(w, 0);
    endtask

    task automatic wait_done(input int prev);
        for (int i = 0; i < 200 && n_done == prev; i++) @(posedge clk);
        #1;
        chk("done_seen", n_done - prev, 1);
    endtask

    int p_cs, p_tc, p_dn, p_rl;

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; tb_sum = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rst_model", rst_model, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_done", done, 0);
        chk("rst_csram_data", csram_data, 0);
        chk("rst_tc_addr", tc_addr, 0);
        rst = 1'b1;

        // TC record then END
        p_tc = n_tc; p_dn = n_done; p_rl = n_rst_low;
        do_start();
        send_word(mk_hdr(2'b01, 5, 'h3A, 2), 0);
        send_end(tb_sum);
        wait_done(p_dn);
        chk("t1_rst_low_cycles", n_rst_low - p_rl, 2);
        chk("t1_tc_strobes", n_tc - p_tc, 1);
        chk("t1_tc_core", tc_core_idx, 5);
        chk("t1_tc_addr", tc_addr, 'h3A);
        chk("t1_tc_data", tc_data, 2);
        chk("t1_error", error, 0);
        chk("t1_rst_model_high", rst_model, 1);

        // CSRAM record with in_valid gaps
        p_cs = n_csram; p_tc = n_tc; p_dn = n_done;
        exp_csram = '0;
        do_start();
        send_word(mk_hdr(2'b00, 0, 'hFF, 0), 1);
        for (int k = 0; k < 12; k++) begin
            exp_csram[k*32 +: 32] = 32'hA5A5_0000 + k;
            send_word(32'hA5A5_0000 + k, 1);
        end
        send_end(tb_sum);
        wait_done(p_dn);
        chk("t2_csram_strobes", n_csram - p_cs, 1);
        chk("t2_tc_strobes", n_tc - p_tc, 0);
        chk("t2_csram_data", csram_data, exp_csram[366:0]);
        chk("t2_csram_addr", csram_addr, 'hFF);
        chk("t2_csram_core", csram_core_idx, 0);
        chk("t2_error", error, 0);

        // out-of-range core, then a valid TC record
        p_cs = n_csram; p_tc = n_tc; p_dn = n_done;
        do_start();
        send_word(mk_hdr(2'b00, 999, 1, 0), 0);
        for (int k = 0; k < 12; k++) send_word(32'h1234_0000 + k, 0);
        send_word(mk_hdr(2'b01, 7, 'h10, 1), 0);
        send_end(tb_sum);
        wait_done(p_dn);
        chk("t3_error", error, 1);
        chk("t3_csram_strobes", n_csram - p_cs, 0);
        chk("t3_tc_strobes", n_tc - p_tc, 1);
        chk("t3_tc_core", tc_core_idx, 7);
        chk("t3_tc_addr", tc_addr, 'h10);
        chk("t3_tc_data", tc_data, 1);
        chk("t3_csram_data_held", csram_data, exp_csram[366:0]);

        // illegal type 10
        do_start();
        send_word(mk_hdr(2'b10, 1, 1, 0), 0);
        chk("t4_error", error, 1);
        chk("t4_busy", busy, 0);
        chk("t4_in_ready", in_ready, 0);
        chk("t4_rst_model", rst_model, 1);
        p_dn = n_done;
        do_start();
        chk("t4_error_cleared", error, 0);
        send_end(tb_sum);
        wait_done(p_dn);

        // reset at beat 6 of a CSRAM record
        p_cs = n_csram;
        do_start();
        send_word(mk_hdr(2'b00, 2, 3, 0), 0);
        for (int k = 0; k < 6; k++) send_word(32'h5A5A_0000 + k, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t5_rst_model", rst_model, 0);
        chk("t5_busy", busy, 0);
        chk("t5_in_ready", in_ready, 0);
        chk("t5_csram_data", csram_data, 0);
        chk("t5_tc_core", tc_core_idx, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_csram_strobes", n_csram - p_cs, 0);

`ifdef MODEL_LOADER_CHECKSUM_EN
        p_dn = n_done;
        do_start();
        send_word(mk_hdr(2'b01, 3, 4, 3), 0);
        send_end(tb_sum + 16'd1);
        wait_done(p_dn);
        chk("cs_bad_error", error, 1);
        p_dn = n_done;
        do_start();
        send_word(mk_hdr(2'b01, 3, 4, 3), 0);
        send_end(tb_sum);
        wait_done(p_dn);
        chk("cs_good_error", error, 0);
`endif

        chk("strobe_while_clear", n_bad_strobe, 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, limit=300000");
        $fatal(1);
    end

endmodule

// File: doc/model_loader.md
Name: model_loader

Overview:
- Drives the per-core model-programming interface of the core array: `rst_model`, the `csram_*` write port and the `tc_*` write port.
- Consumes a host/DMA word stream over a valid/ready handshake and decodes it into records: CSRAM neuron entries, token-controller axon-type entries, and END.
- Issues one single-cycle write strobe per decoded record, broadcast to all cores.
- Owns `rst_model` sequencing: a clear pulse at load start, then held high for the rest of operation, since cores drop `core_active` whenever `rst_model` is low.

Parameters:
- WORD_WIDTH, 32, width of the input stream word.
- NUM_CORES, 999, number of cores; sets core-index width CW = $clog2(NUM_CORES).
- NUM_NEURONS, 256, CSRAM depth; AWN = $clog2(NUM_NEURONS).
- NUM_AXONS, 256, axons per core; AWA = $clog2(NUM_AXONS).
- NUM_WEIGHTS, 4, axon types; WW = $clog2(NUM_WEIGHTS).
- CSRAM_READ_WIDTH, 367, CSRAM entry width; NUM_BEATS = ceil(CSRAM_READ_WIDTH/WORD_WIDTH).
- CLEAR_CYCLES, 2, cycles `rst_model` is held low at load start (must be ≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- start  in  1  begin a load; sampled only in IDLE.
- in_data  in  WORD_WIDTH  stream word.
- in_valid  in  1  stream word valid.
- in_ready  out  1  loader accepts word; transfer occurs when in_valid && in_ready.
- rst_model  out  1  model-modify enable to all cores; low clears core_active.
- csram_data  out  CSRAM_READ_WIDTH  assembled CSRAM entry.
- csram_addr  out  AWN  neuron index.
- csram_core_idx  out  CW  target core.
- csram_valid  out  1  one-cycle CSRAM write strobe.
- tc_data  out  WW  axon type.
- tc_addr  out  AWA  axon index.
- tc_core_idx  out  CW  target core.
- tc_valid  out  1  one-cycle TC write strobe.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on successful END.
- error  out  1  sticky error flag; cleared by reset or an accepted start.

Behaviour:
- Reset values:
  - State = IDLE.
  - `rst_model` = 0.
  - `in_ready`, `csram_valid`, `tc_valid`, `busy`, `done`, `error` = 0.
  - All data, address and index outputs = 0; beat counter = 0.
- Header word fields, from the MSB down:
  - type [WORD_WIDTH-1 : WORD_WIDTH-2]: 00 = CSRAM, 01 = TC, 11 = END, 10 = illegal.
  - core_idx: next CW bits.
  - addr: next max(AWN, AWA) bits; the low AWN or AWA bits are used.
  - tc_data: bits [WW-1:0].
  - Field widths must satisfy 2 + CW + max(AWN, AWA) + WW ≤ WORD_WIDTH; otherwise elaboration fails via a generate-time $error.
- State machine:
  - IDLE: `in_ready` = 0; `rst_model` holds its last value. On start → CLEAR, clear `error`, drive `rst_model` = 0.
  - CLEAR: `rst_model` = 0 for exactly CLEAR_CYCLES cycles → HEADER.
  - HEADER: `in_ready` = 1, `rst_model` = 1. On handshake, decode the type:
    - CSRAM: latch core_idx/addr, zero the assembly register, beat counter = 0 → DATA.
    - TC: latch fields → ISSUE.
    - END → IDLE with a `done` pulse.
    - Illegal (10): set `error` → IDLE, `rst_model` stays 1.
  - DATA: `in_ready` = 1. Beat k is written to assembly bits [k*WORD_WIDTH +: WORD_WIDTH]; the final beat is truncated to CSRAM_READ_WIDTH (LSW first). After beat NUM_BEATS-1 → ISSUE.
  - ISSUE: `in_ready` = 0. Assert exactly one of `csram_valid` / `tc_valid` for 1 cycle, with data, address and index stable in the same cycle → HEADER.
- Range check: a record with core_idx ≥ NUM_CORES sets `error`. Its data beats are still consumed, no strobe is issued, and decoding continues.
- Strobes are never asserted while `rst_model` = 0.
- Outputs hold their last values between strobes.
- Throughput:
  - CSRAM record: 1 + NUM_BEATS + 1 cycles minimum (14 at defaults).
  - TC record: 2 cycles.
- `in_valid` gaps stall the FSM with no state change.
- `start` while busy is ignored.
- Reset mid-record: the partial record is discarded, no strobe is emitted, and `rst_model` = 0.

Optional Feature:
- Macro: MODEL_LOADER_CHECKSUM_EN.
- Defined:
  - A 16-bit running sum (mod 2^16) covers every accepted word before END, across header and data words.
  - On END, the sum is compared against END word bits [15:0].
  - Match → `done` pulse. Mismatch → `error` = 1 and `done` pulse.
- Undefined: the END payload is ignored; no accumulator logic is present.

Test Plan:
- Reset, then start; stream one TC header (core 5, addr 0x3A, type 2), then END → `rst_model` low 2 cycles then high; `tc_valid` 1 cycle with `tc_core_idx` = 5, `tc_addr` = 0x3A, `tc_data` = 2; `done` pulse; `error` = 0.
- CSRAM header (core 0, addr 0xFF) plus 12 beats of pattern 0xA5A5_0000+k, with in_valid toggled every other cycle → single `csram_valid`; `csram_data` equals the concatenated beats truncated to 367 bits; `csram_addr` = 0xFF.
- Header with core_idx = 999 followed by 12 data beats, then a valid TC record → `error` = 1, no `csram_valid`, the TC strobe still issues.
- Illegal type 10 header → `error` = 1, FSM back in IDLE, `in_ready` = 0, `rst_model` stays 1; next start clears `error`.
- Reset asserted at beat 6 of a CSRAM record → no strobe, all outputs at reset values, `rst_model` = 0.
- MODEL_LOADER_CHECKSUM_EN: one TC record whose END carries a wrong sum → `done` and `error` = 1; with the correct sum → `error` = 0.
